// File: rtl/piece_bag_generator.sv
// piece_bag_generator: 7-bag tetromino randomizer with a one-deep preview,
// request/valid handshake and a completed-bag counter for telemetry.
`default_nettype none

module piece_bag_generator #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_TRIES = 8
) (
  input  logic        game_clk,
  input  logic        reset_n,
  input  logic        piece_request,
  input  logic        seed_load,
  input  logic [15:0] seed_value,
  output logic        piece_valid,
  output logic [2:0]  current_piece,
  output logic [2:0]  next_piece,
  output logic [2:0]  bag_remaining,
  output logic [7:0]  bag_count
);

  localparam logic [15:0] POLY_MASK = 16'hB400;
  localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [3:0]  TRY_LIMIT = 4'(MAX_TRIES);

  typedef enum logic [1:0] {
    FILL_CUR  = 2'd0,
    FILL_NEXT = 2'd1,
    READY     = 2'd2,
    DRAW      = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [6:0]  used_q, used_d;
  logic [3:0]  try_q, try_d;
  logic [2:0]  rem_q, rem_d;
  logic [7:0]  bags_q, bags_d;
  logic [2:0]  cur_q, cur_d;
  logic [2:0]  next_q, next_d;
  logic        valid_q, valid_d;

  logic [15:0] lfsr_shift;
  logic [2:0]  cand;
  logic [7:0]  taken;
  logic [2:0]  lowest_free;
  logic        forced;
  logic        rand_ok;
  logic        is_draw;
  logic        accept;
  logic [2:0]  pick;
  logic [6:0]  used_set;
  logic        bag_done;

  // Index 7 is never a piece, so it is permanently marked as taken.
  assign taken = {1'b1, used_q};
  assign cand  = lfsr_q[2:0];

  always_comb begin
    lowest_free = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (!used_q[i]) lowest_free = 3'(i);
    end
  end

  always_comb begin
    lfsr_shift = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY_MASK) : (lfsr_q >> 1);
    if (seed_load) begin
      lfsr_d = (seed_value == 16'h0000) ? 16'h0001 : seed_value;
    end else begin
      lfsr_d = lfsr_shift;
    end
  end

  assign is_draw  = (state_q != READY);
  assign forced   = (try_q == TRY_LIMIT);
  assign rand_ok  = !taken[cand] && (try_q < TRY_LIMIT);
  assign accept   = is_draw && (rand_ok || forced);
  assign pick     = forced ? lowest_free : cand;
  assign used_set = used_q | (7'd1 << pick);
  assign bag_done = (used_set == 7'h7F);

  always_comb begin
    state_d = state_q;
    used_d  = used_q;
    try_d   = try_q;
    rem_d   = rem_q;
    bags_d  = bags_q;
    cur_d   = cur_q;
    next_d  = next_q;
    valid_d = valid_q;

    if (accept) begin
      try_d = 4'd0;
      if (bag_done) begin
        used_d = 7'd0;
        rem_d  = 3'd7;
        bags_d = bags_q + 8'd1;
      end else begin
        used_d = used_set;
        rem_d  = rem_q - 3'd1;
      end
    end else if (is_draw) begin
      try_d = try_q + 4'd1;
    end

    case (state_q)
      FILL_CUR: begin
        if (accept) begin
          cur_d   = pick;
          state_d = FILL_NEXT;
        end
      end
      FILL_NEXT, DRAW: begin
        if (accept) begin
          next_d  = pick;
          valid_d = 1'b1;
          state_d = READY;
        end
      end
      READY: begin
        if (piece_request && valid_q) begin
          cur_d   = next_q;
          valid_d = 1'b0;
          state_d = DRAW;
        end
      end
      default: state_d = FILL_CUR;
    endcase
  end

  always_ff @(posedge game_clk) begin
    if (!reset_n) begin
      state_q <= FILL_CUR;
      lfsr_q  <= SEED_SAFE;
      used_q  <= 7'd0;
      try_q   <= 4'd0;
      rem_q   <= 3'd7;
      bags_q  <= 8'd0;
      cur_q   <= 3'd0;
      next_q  <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      used_q  <= used_d;
      try_q   <= try_d;
      rem_q   <= rem_d;
      bags_q  <= bags_d;
      cur_q   <= cur_d;
      next_q  <= next_d;
      valid_q <= valid_d;
    end
  end

  assign piece_valid   = valid_q;
  assign current_piece = cur_q;
  assign next_piece    = next_q;
  assign bag_remaining = rem_q;
  assign bag_count     = bags_q;

endmodule

`default_nettype wire

// File: tb/tb_piece_bag_generator.sv
// tb_piece_bag_generator: directed vector table plus hand-written sequences,
// with a cycle model of the 7-bag generator compared on every falling edge.
`default_nettype none

module tb_piece_bag_generator;

  localparam int MAX_T = 8;
  localparam int ST_FILL_CUR = 0, ST_FILL_NEXT = 1, ST_READY = 2, ST_DRAW = 3;

  logic        game_clk = 1'b0;
  logic        reset_n;
  logic        piece_request;
  logic        seed_load;
  logic [15:0] seed_value;
  logic        piece_valid;
  logic [2:0]  current_piece;
  logic [2:0]  next_piece;
  logic [2:0]  bag_remaining;
  logic [7:0]  bag_count;

  int n_tests = 0;
  int n_fail  = 0;

  piece_bag_generator #(.SEED(16'hACE1), .MAX_TRIES(MAX_T)) dut (
    .game_clk      (game_clk),
    .reset_n       (reset_n),
    .piece_request (piece_request),
    .seed_load     (seed_load),
    .seed_value    (seed_value),
    .piece_valid   (piece_valid),
    .current_piece (current_piece),
    .next_piece    (next_piece),
    .bag_remaining (bag_remaining),
    .bag_count     (bag_count)
  );

  always #5 game_clk = ~game_clk;

  function automatic logic [15:0] galois(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Reference model, advanced on the same rising edge as the DUT.
  int          m_state = ST_FILL_CUR;
  int          m_try   = 0;
  logic [15:0] m_lfsr  = 16'hACE1;
  logic [7:0]  m_used  = 8'd0;
  logic [2:0]  m_rem   = 3'd7;
  logic [7:0]  m_bags  = 8'd0;
  logic [2:0]  m_cur   = 3'd0;
  logic [2:0]  m_next  = 3'd0;
  logic        m_valid = 1'b0;

  always @(posedge game_clk) begin : model
    logic [2:0] c;
    logic [2:0] p;
    logic       acc;
    if (!reset_n) begin
      m_state = ST_FILL_CUR; m_try = 0; m_lfsr = 16'hACE1; m_used = 8'd0;
      m_rem = 3'd7; m_bags = 8'd0; m_cur = 3'd0; m_next = 3'd0; m_valid = 1'b0;
    end else begin
      c = m_lfsr[2:0];
      p = 3'd0;
      acc = 1'b0;
      if (m_state == ST_READY) begin
        if (piece_request && m_valid) begin
          m_cur = m_next; m_valid = 1'b0; m_state = ST_DRAW;
        end
      end else begin
        if (m_try == MAX_T) begin
          acc = 1'b1;
          for (int i = 6; i >= 0; i--) if (!m_used[i]) p = 3'(i);
        end else if (c != 3'd7 && !m_used[c]) begin
          acc = 1'b1; p = c;
        end else begin
          m_try = m_try + 1;
        end
        if (acc) begin
          m_try = 0;
          m_used[p] = 1'b1;
          if (m_rem == 3'd1) begin
            m_used = 8'd0; m_rem = 3'd7; m_bags = m_bags + 8'd1;
          end else begin
            m_rem = m_rem - 3'd1;
          end
          if (m_state == ST_FILL_CUR) begin
            m_cur = p; m_state = ST_FILL_NEXT;
          end else begin
            m_next = p; m_valid = 1'b1; m_state = ST_READY;
          end
        end
      end
      m_lfsr = seed_load ? ((seed_value == 16'h0) ? 16'h1 : seed_value) : galois(m_lfsr);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge game_clk);
    n_tests++;
    if ({piece_valid, current_piece, next_piece, bag_remaining, bag_count} !==
        {m_valid, m_cur, m_next, m_rem, m_bags}) begin
      n_fail++;
      $display("FAIL cycle_model t=%0t got v%0d c%0d n%0d r%0d b%0d expected v%0d c%0d n%0d r%0d b%0d",
               $time, piece_valid, current_piece, next_piece, bag_remaining, bag_count,
               m_valid, m_cur, m_next, m_rem, m_bags);
    end
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!piece_valid && n < budget) begin
      tick();
      n++;
    end
    if (!piece_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL valid_timeout: got no piece_valid after %0d cycles, expected within %0d", n, budget);
    end
  endtask

  logic [2:0] seq[$];

  task automatic start_run(input logic do_load, input logic [15:0] s);
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    if (do_load) begin
      seed_load = 1'b1; seed_value = s;
      tick();
      seed_load = 1'b0;
      if (s == 16'h0000) check("seed_zero_forced", dut.lfsr_q, 32'h1);
    end
    seq.delete();
    wait_valid(2 * (MAX_T + 1));
    seq.push_back(current_piece);
    seq.push_back(next_piece);
  endtask

  task automatic do_req();
    wait_valid(MAX_T + 3);
    piece_request = 1'b1;
    tick();
    piece_request = 1'b0;
    wait_valid(MAX_T + 2);
    seq.push_back(next_piece);
  endtask

  task automatic check_perms();
    for (int g = 0; g < seq.size() / 7; g++) begin
      logic [7:0] mask = 8'd0;
      for (int k = 0; k < 7; k++) mask[seq[g*7+k]] = 1'b1;
      check($sformatf("perm_bag%0d", g), mask, 32'h7F);
    end
  endtask

  typedef struct {
    logic [15:0] seed;
    int          nreq;
    int          exp_bags;
    int          exp_rem;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [2:0]  seq_a[$];
    logic [2:0]  old_next;
    logic [7:0]  mask;
    logic [2:0]  missing;
    logic [15:0] l;
    logic [15:0] found;
    logic        ok;
    int          n;

    vecs[0] = '{16'hACE1,  5, 1, 7};
    vecs[1] = '{16'h1234, 19, 3, 7};
    vecs[2] = '{16'h0000,  3, 0, 2};
    vecs[3] = '{16'hFFFF, 10, 1, 2};
    vecs[4] = '{16'h8001,  0, 0, 5};

    piece_request = 1'b0; seed_load = 1'b0; seed_value = 16'h0; reset_n = 1'b0;

    // Reset values, then first fill from the parameter seed.
    repeat (3) tick();
    check("rst_valid", piece_valid, 0);
    check("rst_cur", current_piece, 0);
    check("rst_next", next_piece, 0);
    check("rst_remaining", bag_remaining, 7);
    check("rst_bag_count", bag_count, 0);
    reset_n = 1'b1;
    wait_valid(2 * (MAX_T + 1));
    check("fill_distinct", current_piece != next_piece, 1);
    check("fill_remaining", bag_remaining, 5);
    check("fill_bag_count", bag_count, 0);

    foreach (vecs[v]) begin
      start_run(1'b1, vecs[v].seed);
      for (int r = 0; r < vecs[v].nreq; r++) do_req();
      check($sformatf("vec%0d_bag_count", v), bag_count, vecs[v].exp_bags);
      check($sformatf("vec%0d_remaining", v), bag_remaining, vecs[v].exp_rem);
      check_perms();
    end

    // Identical seed and timing give identical 14-piece sequences.
    start_run(1'b1, 16'h5A5A);
    for (int r = 0; r < 12; r++) do_req();
    seq_a = seq;
    start_run(1'b1, 16'h5A5A);
    for (int r = 0; r < 12; r++) do_req();
    for (int k = 0; k < 14; k++) check($sformatf("repeat_seq%0d", k), seq[k], seq_a[k]);

    // Requests in FILL_CUR and while piece_valid is low are dropped.
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    piece_request = 1'b1;
    tick();
    piece_request = 1'b0;
    wait_valid(2 * (MAX_T + 1));
    check("fill_req_ignored", bag_remaining, 5);
    old_next = next_piece;
    piece_request = 1'b1;
    tick();
    tick();
    piece_request = 1'b0;
    wait_valid(MAX_T + 2);
    check("no_double_advance", current_piece, old_next);
    check("no_double_remaining", bag_remaining, 4);

    // Fallback: seed chosen so that 8 candidates all miss the last free index.
    start_run(1'b0, 16'h0);
    for (int r = 0; r < 4; r++) do_req();
    mask = 8'd0;
    for (int k = 0; k < 6; k++) mask[seq[k]] = 1'b1;
    missing = 3'd0;
    for (int i = 6; i >= 0; i--) if (!mask[i]) missing = 3'(i);
    found = 16'h0;
    for (int s = 1; s < 4096 && found == 16'h0; s++) begin
      l = 16'(s);
      ok = 1'b1;
      for (int k = 0; k < MAX_T; k++) begin
        if (l[2:0] == missing) ok = 1'b0;
        l = galois(l);
      end
      if (ok) found = 16'(s);
    end
    check("fallback_seed_found", found != 16'h0, 1);
    piece_request = 1'b1; seed_load = 1'b1; seed_value = found;
    tick();
    piece_request = 1'b0; seed_load = 1'b0;
    n = 0;
    while (!piece_valid && n < 2 * MAX_T) begin
      tick();
      n++;
    end
    check("fallback_latency", n, MAX_T + 1);
    check("fallback_piece", next_piece, missing);
    check("fallback_bag_count", bag_count, 1);
    check("fallback_remaining", bag_remaining, 7);

    // Reset while a DRAW is in progress.
    piece_request = 1'b1;
    tick();
    piece_request = 1'b0;
    check("mid_draw_state", piece_valid, 0);
    reset_n = 1'b0;
    tick();
    check("mid_rst_valid", piece_valid, 0);
    check("mid_rst_bag_count", bag_count, 0);
    check("mid_rst_remaining", bag_remaining, 7);
    check("mid_rst_cur", current_piece, 0);
    reset_n = 1'b1;
    wait_valid(2 * (MAX_T + 1));
    check("restart_fill", bag_remaining, 5);

    // 255 bags, then the 256th wraps the counter.
    for (int r = 0; r < 1783; r++) do_req();
    check("bags_255", bag_count, 255);
    check("bags_255_remaining", bag_remaining, 7);
    for (int r = 0; r < 7; r++) do_req();
    check("bags_wrap", bag_count, 0);
    check("bags_wrap_remaining", bag_remaining, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
